mem_axi_master: RTL and testbench

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

---
 rtl/mem_axi_master_pkg.sv | 31 +++
 rtl/mem_axi_master.sv | 205 ++++++++++++++++++++
 tb/tb_mem_axi_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_axi_master_pkg.sv
// mem_axi_master_pkg: shared definitions for the single-outstanding AXI-style
// memory master.
//   - state_e         : FSM state encoding
//   - AXI_RESP_*      : AXI response codes seen on bresp/rresp
//   - state_known()   : flags whether a state register value is a legal encoding
package mem_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Two of the eight 3-bit codes are unused; the FSM treats them as IDLE.
    function automatic logic state_known(input state_e s);
        logic known;
        case (s)
            ST_IDLE, ST_RD_ADDR, ST_RD_DATA,
            ST_WR_REQ, ST_WR_RESP, ST_RESP: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mem_axi_master.sv
// mem_axi_master: turns single core requests into AXI-style read (AR/R) or
// write (AW/W/B) transactions, one transaction outstanding at a time.
// Ports:
//   clk, rst                 : rising-edge clock, asynchronous active-high reset
//   req_*                    : core request (valid/ready, we, addr, wdata, wmask)
//   rsp_valid/rsp_rdata/err  : one-cycle completion pulse with read data / error
//   aw*, w*, b*              : AXI write address, write data, write response
//   ar*, r*                  : AXI read address, read data
// Every output comes straight from a flop; next values are derived from the
// next state so they line up with the state register.
module mem_axi_master
    import mem_axi_master_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [addr_width-1:0]   req_addr,
    input  logic [data_width-1:0]   req_wdata,
    input  logic [data_width/8-1:0] req_wmask,
    output logic                    rsp_valid,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [addr_width-1:0]   awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [data_width-1:0]   wdata,
    output logic [data_width/8-1:0] wmask,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [addr_width-1:0]   araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [data_width-1:0]   rdata,
    input  logic [1:0]              rresp
);

    localparam int mask_width = data_width / 8;

    state_e                  state_q, state_d, state_s;
    logic                    we_q, we_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic [mask_width-1:0]   wmask_q, wmask_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [data_width-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;

    // Next-state, request latching and next-output computation.
    always_comb begin
        state_s     = state_known(state_q) ? state_q : ST_IDLE;
        state_d     = state_s;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_s)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d      = req_we;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wmask_d   = req_wmask;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? ST_WR_REQ : ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && arready) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && rvalid) begin
                    rsp_rdata_d = rdata;
                    rsp_err_d   = (rresp != AXI_RESP_OKAY);
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; leave as soon as both have,
                // even if they finish on the same edge.
                aw_done_d = aw_done_q | (awvalid_q & awready);
                w_done_d  = w_done_q | (wvalid_q & wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && bvalid) begin
                    rsp_err_d = (bresp != AXI_RESP_OKAY);
                    state_d   = ST_RESP;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        arvalid_d   = (state_d == ST_RD_ADDR);
        rready_d    = (state_d == ST_RD_DATA);
        awvalid_d   = (state_d == ST_WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == ST_WR_REQ) && !w_done_d;
        bready_d    = (state_d == ST_WR_RESP);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State, request and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign rready    = rready_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign wmask     = wmask_q;
    assign bready    = bready_q;

    // we_q is held for completeness of the latched request; direction is
    // already encoded in the state path.
    logic unused_s;
    assign unused_s = we_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// tb_mem_axi_master: self-checking bench for mem_axi_master. A slave model with
// programmable per-channel delays answers AXI traffic; a transaction-level
// model predicts each response and the ready/handshake behaviour.
module tb_mem_axi_master;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic [MW-1:0] wmask;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    mem_axi_master #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wmask(wmask),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave knobs
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = 2'b00, s_bresp = 2'b00;
    bit            spurious = 1'b0;

    // slave state
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit pend_r, pend_b, got_aw, got_w;

    // DUT outputs as sampled at the previous falling edge
    logic          p_req_ready, p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
    logic [AW-1:0] p_araddr, p_awaddr;
    logic [DW-1:0] p_wdata;
    logic [MW-1:0] p_wmask;

    // event log
    int n_acc = 0, n_rsp = 0, n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    int acc_cyc, rsp_cyc, ar_cyc, aw_cyc, w_cyc;
    logic [AW-1:0] hs_araddr, hs_awaddr;
    logic [DW-1:0] hs_wdata;
    logic [MW-1:0] hs_wmask;
    logic [DW-1:0] got_rdata;
    logic          got_err;
    int inflight = 0, stab_viol = 0, ready_viol = 0;
    logic [DW-1:0] mdl_rdata = '0;

    task automatic sample_prev();
        p_req_ready = req_ready; p_arvalid = arvalid; p_rready = rready;
        p_awvalid = awvalid; p_wvalid = wvalid; p_bready = bready;
        p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wmask = wmask;
    endtask

    task automatic clear_bench();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        rdata = '0; rresp = 2'b00; bresp = 2'b00;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        pend_r = 1'b0; pend_b = 1'b0; got_aw = 1'b0; got_w = 1'b0;
        inflight = 0; mdl_rdata = '0;
        p_req_ready = 1'b0; p_arvalid = 1'b0; p_rready = 1'b0;
        p_awvalid = 1'b0; p_wvalid = 1'b0; p_bready = 1'b0;
    endtask

    // Advance one cycle: log handshakes of the last rising edge, then drive the slave.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (p_req_ready && req_valid) begin n_acc++; acc_cyc = cyc - 1; inflight++; end
        if (p_arvalid && arready) begin
            n_ar++; ar_cyc = cyc - 1; hs_araddr = p_araddr; pend_r = 1'b1; r_wait = 0; ar_wait = 0;
        end
        if (p_rready && rvalid) begin n_r++; pend_r = 1'b0; end
        if (p_bready && bvalid) begin n_b++; pend_b = 1'b0; end
        if (p_awvalid && awready) begin
            n_aw++; aw_cyc = cyc - 1; hs_awaddr = p_awaddr; got_aw = 1'b1; aw_wait = 0;
        end
        if (p_wvalid && wready) begin
            n_w++; w_cyc = cyc - 1; hs_wdata = p_wdata; hs_wmask = p_wmask; got_w = 1'b1; w_wait = 0;
        end
        if (got_aw && got_w) begin pend_b = 1'b1; b_wait = 0; got_aw = 1'b0; got_w = 1'b0; end

        if (p_arvalid && !arready && (arvalid !== 1'b1 || araddr !== p_araddr)) stab_viol++;
        if (p_awvalid && !awready && (awvalid !== 1'b1 || awaddr !== p_awaddr)) stab_viol++;
        if (p_wvalid && !wready && (wvalid !== 1'b1 || wdata !== p_wdata || wmask !== p_wmask)) stab_viol++;

        if (req_ready !== (inflight == 0)) ready_viol++;
        if (rsp_valid === 1'b1) begin
            n_rsp++; rsp_cyc = cyc; got_rdata = rsp_rdata; got_err = rsp_err; inflight--;
        end

        arready = 1'b0;
        if (arvalid === 1'b1) begin arready = (ar_wait >= ar_delay); ar_wait++; end
        awready = 1'b0;
        if (awvalid === 1'b1) begin awready = (aw_wait >= aw_delay); aw_wait++; end
        wready = 1'b0;
        if (wvalid === 1'b1) begin wready = (w_wait >= w_delay); w_wait++; end
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        if (pend_r) begin
            if (r_wait >= r_delay) begin rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; end
            r_wait++;
        end
        bvalid = 1'b0; bresp = 2'b00;
        if (pend_b) begin
            if (b_wait >= b_delay) begin bvalid = 1'b1; bresp = s_bresp; end
            b_wait++;
        end
        if (spurious) begin
            rvalid = 1'b1; bvalid = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            rresp = 2'b10; bresp = 2'b10;
        end
        sample_prev();
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, output bit ok);
        int start;
        start = n_acc;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        for (int i = 0; i < 50; i++) begin
            step();
            if (n_acc != start) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_rsp != start) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_bench();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready} !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 10000000",
                {req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (rsp_rdata !== 64'h0 || araddr !== 32'h0 || wdata !== 64'h0 || wmask !== 8'h0) begin
            errors++; $display("FAIL reset_data: rdata %h araddr %h wdata %h wmask %h expected zeros",
                rsp_rdata, araddr, wdata, wmask);
        end
        rst = 1'b0;
        sample_prev();
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_read_basic();
        bit ok;
        int r0;
        ar_delay = 0; r_delay = 0;
        s_rdata = 64'h0123_4567_89AB_CDEF; s_rresp = 2'b00;
        r0 = n_rsp;
        issue(1'b0, 32'h0000_1000, 64'h0, 8'h0, ok);
        wait_rsp(r0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_timeout: got no response expected one"); end
        checks++;
        if (ar_cyc - acc_cyc != 1) begin errors++; $display("FAIL read_ar_lat: got %0d expected 1", ar_cyc - acc_cyc); end
        checks++;
        if (rsp_cyc - acc_cyc != 3) begin errors++; $display("FAIL read_rsp_lat: got %0d expected 3", rsp_cyc - acc_cyc); end
        checks++;
        if (got_rdata !== s_rdata) begin errors++; $display("FAIL read_rdata: got %h expected %h", got_rdata, s_rdata); end
        checks++;
        if (got_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", got_err); end
        checks++;
        if (hs_araddr !== 32'h0000_1000) begin errors++; $display("FAIL read_araddr: got %h expected 00001000", hs_araddr); end
        mdl_rdata = s_rdata;
        repeat (3) step();
        checks++;
        if (n_rsp != r0 + 1) begin errors++; $display("FAIL read_pulse: got %0d pulses expected 1", n_rsp - r0); end
    endtask

    task automatic test_write_aw_late();
        bit ok;
        int r0, aw0, w0, b0, sv0;
        aw_delay = 3; w_delay = 0; b_delay = 0; s_bresp = 2'b00;
        r0 = n_rsp; aw0 = n_aw; w0 = n_w; b0 = n_b; sv0 = stab_viol;
        issue(1'b1, 32'h0000_0100, 64'h0000_0000_0000_00FF, 8'h0F, ok);
        wait_rsp(r0, ok);
        repeat (3) step();
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout: got no response expected one"); end
        checks++;
        if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_b - b0 != 1) begin
            errors++; $display("FAIL write_hs_count: aw %0d w %0d b %0d expected 1 1 1", n_aw - aw0, n_w - w0, n_b - b0);
        end
        checks++;
        if (aw_cyc - w_cyc != 3) begin errors++; $display("FAIL write_aw_after_w: got %0d expected 3", aw_cyc - w_cyc); end
        checks++;
        if (n_rsp - r0 != 1) begin errors++; $display("FAIL write_pulse: got %0d expected 1", n_rsp - r0); end
        checks++;
        if (hs_awaddr !== 32'h100 || hs_wdata !== 64'hFF || hs_wmask !== 8'h0F) begin
            errors++; $display("FAIL write_payload: got %h %h %h expected 00000100 ff 0f", hs_awaddr, hs_wdata, hs_wmask);
        end
        checks++;
        if (stab_viol != sv0) begin errors++; $display("FAIL write_stable: got %0d violations expected 0", stab_viol - sv0); end
        checks++;
        if (got_err !== 1'b0 || got_rdata !== mdl_rdata) begin
            errors++; $display("FAIL write_rsp: err %b rdata %h expected 0 %h", got_err, got_rdata, mdl_rdata);
        end
        aw_delay = 0;
    endtask

    task automatic test_err_then_ok();
        bit ok;
        int r0;
        s_bresp = 2'b10;
        r0 = n_rsp;
        issue(1'b1, 32'h0000_0200, 64'h1111_2222_3333_4444, 8'hFF, ok);
        wait_rsp(r0, ok);
        checks++;
        if (!ok || got_err !== 1'b1 || got_rdata !== mdl_rdata) begin
            errors++; $display("FAIL slverr_write: ok %0d err %b rdata %h expected 1 1 %h", ok, got_err, got_rdata, mdl_rdata);
        end
        s_bresp = 2'b00;
        s_rdata = 64'hA5A5_0000_FFFF_1234; s_rresp = 2'b00;
        r0 = n_rsp;
        issue(1'b0, 32'h0000_0300, 64'h0, 8'h0, ok);
        wait_rsp(r0, ok);
        checks++;
        if (!ok || got_err !== 1'b0 || got_rdata !== s_rdata) begin
            errors++; $display("FAIL err_clears: ok %0d err %b rdata %h expected 1 0 %h", ok, got_err, got_rdata, s_rdata);
        end
        mdl_rdata = s_rdata;
    endtask

    task automatic test_back_to_back();
        int a0, r0, ar0, aw0, rv0;
        bit ok;
        a0 = n_acc; r0 = n_rsp; ar0 = n_ar; aw0 = n_aw; rv0 = ready_viol;
        s_rdata = 64'h0F0F_F0F0_1357_9BDF; s_rresp = 2'b00; s_bresp = 2'b00;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400;
        for (int i = 0; i < 50 && n_acc == a0; i++) step();
        req_we = 1'b1; req_addr = 32'h0000_0500; req_wdata = 64'h7777; req_wmask = 8'h3C;
        for (int i = 0; i < 50 && n_acc == a0 + 1; i++) step();
        req_valid = 1'b0;
        wait_rsp(r0 + 1, ok);
        repeat (4) step();
        checks++;
        if (n_acc - a0 != 2 || n_rsp - r0 != 2) begin
            errors++; $display("FAIL b2b_counts: acc %0d rsp %0d expected 2 2", n_acc - a0, n_rsp - r0);
        end
        checks++;
        if (ready_viol != rv0) begin errors++; $display("FAIL b2b_ready: got %0d violations expected 0", ready_viol - rv0); end
        checks++;
        if (n_ar - ar0 != 1 || n_aw - aw0 != 1 || !(ar_cyc < aw_cyc)) begin
            errors++; $display("FAIL b2b_order: ar %0d@%0d aw %0d@%0d expected AR first", n_ar - ar0, ar_cyc, n_aw - aw0, aw_cyc);
        end
        checks++;
        if (hs_araddr !== 32'h400 || hs_awaddr !== 32'h500 || got_rdata !== s_rdata) begin
            errors++; $display("FAIL b2b_data: ar %h aw %h rdata %h expected 400 500 %h", hs_araddr, hs_awaddr, got_rdata, s_rdata);
        end
        mdl_rdata = s_rdata;
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int r0, rr0;
        r_delay = 1000;
        issue(1'b0, 32'h0000_0600, 64'h0, 8'h0, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rready === 1'b1) begin seen = 1'b1; break; end
            step();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mid_reach: got no rready expected rready"); end
        rst = 1'b1;
        clear_bench();
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready} !== 8'b1000_0000) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b expected 10000000",
                {req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0", rsp_rdata); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r_delay = 0;
        r0 = n_rsp; rr0 = n_r;
        sample_prev();
        spurious = 1'b1;
        repeat (10) step();
        spurious = 1'b0;
        step();
        checks++;
        if (n_rsp != r0 || n_r != rr0) begin
            errors++; $display("FAIL rst_mid_spurious: rsp %0d r_hs %0d expected 0 0", n_rsp - r0, n_r - rr0);
        end
    endtask

    task automatic test_ar_delay();
        bit ok;
        int r0, ar0, sv0;
        ar_delay = 5; r_delay = 0;
        s_rdata = 64'hCAFE_F00D_0000_0005; s_rresp = 2'b00;
        r0 = n_rsp; ar0 = n_ar; sv0 = stab_viol;
        issue(1'b0, 32'h0000_0700, 64'h0, 8'h0, ok);
        wait_rsp(r0, ok);
        checks++;
        if (!ok || n_ar - ar0 != 1) begin errors++; $display("FAIL ar_delay_hs: ok %0d ar %0d expected 1 1", ok, n_ar - ar0); end
        checks++;
        if (ar_cyc - acc_cyc != 6) begin errors++; $display("FAIL ar_delay_lat: got %0d expected 6", ar_cyc - acc_cyc); end
        checks++;
        if (stab_viol != sv0 || hs_araddr !== 32'h700) begin
            errors++; $display("FAIL ar_delay_stable: viol %0d addr %h expected 0 700", stab_viol - sv0, hs_araddr);
        end
        checks++;
        if (got_rdata !== s_rdata || got_err !== 1'b0) begin
            errors++; $display("FAIL ar_delay_rsp: got %h %b expected %h 0", got_rdata, got_err, s_rdata);
        end
        mdl_rdata = s_rdata;
        ar_delay = 0;
    endtask

    task automatic test_random();
        bit ok;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, exp_rdata;
        logic [MW-1:0] m;
        logic exp_err;
        int r0;
        for (int t = 0; t < 24; t++) begin
            ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3);
            s_rdata = {$urandom(), $urandom()};
            s_rresp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            s_bresp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            we = ($urandom_range(0, 1) == 1);
            a = $urandom() & 32'hFFFF_FFF8;
            d = {$urandom(), $urandom()};
            m = $urandom_range(0, 255);
            if (we) begin exp_rdata = mdl_rdata; exp_err = (s_bresp != 2'b00); end
            else begin exp_rdata = s_rdata; exp_err = (s_rresp != 2'b00); end
            r0 = n_rsp;
            issue(we, a, d, m, ok);
            wait_rsp(r0, ok);
            step(); step();
            checks++;
            if (!ok || n_rsp - r0 != 1) begin errors++; $display("FAIL rnd_pulse[%0d]: got %0d expected 1", t, n_rsp - r0); end
            checks++;
            if (got_rdata !== exp_rdata || got_err !== exp_err) begin
                errors++; $display("FAIL rnd_rsp[%0d]: got %h %b expected %h %b", t, got_rdata, got_err, exp_rdata, exp_err);
            end
            checks++;
            if (we && (hs_awaddr !== a || hs_wdata !== d || hs_wmask !== m)) begin
                errors++; $display("FAIL rnd_wr_payload[%0d]: got %h %h %h expected %h %h %h", t, hs_awaddr, hs_wdata, hs_wmask, a, d, m);
            end else if (!we && hs_araddr !== a) begin
                errors++; $display("FAIL rnd_araddr[%0d]: got %h expected %h", t, hs_araddr, a);
            end
            mdl_rdata = exp_rdata;
        end
        checks++;
        if (stab_viol != 0 || ready_viol != 0) begin
            errors++; $display("FAIL protocol: stability %0d ready %0d expected 0 0", stab_viol, ready_viol);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_aw_late();
        test_err_then_ok();
        test_back_to_back();
        test_reset_mid();
        test_ar_delay();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
